// File: rtl/seg7_scan_counter.sv
// Multi-digit BCD up/down counter with prescaled stepping and a time-multiplexed
// seven-segment display driver with leading-zero blanking.
module seg7_scan_counter #(
   parameter int unsigned DIGITS     = 4,
   parameter int unsigned TICK_DIV   = 1000,
   parameter int unsigned SCAN_DIV   = 250,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic                  count_en,
   input  logic                  up_dn,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     dig_sel,
   output logic [4*DIGITS-1:0]   count,
   output logic                  wrap
);

   localparam int unsigned CW = 4 * DIGITS;
   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Output polarity masks; applied only where the display registers are loaded.
   localparam logic [6:0]        POL7    = {7{ACTIVE_LOW}};
   localparam logic [DIGITS-1:0] POLD    = {DIGITS{ACTIVE_LOW}};
   localparam logic [6:0]        SEG_RST = 7'b0111111 ^ POL7;
   localparam logic [DIGITS-1:0] DIG_RST = DIGITS'(1) ^ POLD;

   logic [PW-1:0]     presc_q, presc_d;
   logic [SW-1:0]     scan_q, scan_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [CW-1:0]     count_q, count_d;
   logic              wrap_q, wrap_d;
   logic [6:0]        seg_q, seg_d;
   logic [DIGITS-1:0] dig_sel_q, dig_sel_d;

   logic              tick_c;
   logic              step_c;
   logic              carry;
   logic              hi_nz;
   logic              blank;
   logic [3:0]        nib;
   logic [3:0]        cur_dig;
   logic [CW-1:0]     load_san;
   logic [CW-1:0]     stepped;

   function automatic logic [6:0] dec7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   // Next-state logic for prescaler, counter, scan index and display registers.
   always_comb begin
      presc_d   = presc_q;
      count_d   = count_q;
      wrap_d    = 1'b0;
      scan_d    = scan_q;
      idx_d     = idx_q;
      seg_d     = seg_q;
      dig_sel_d = dig_sel_q;
      load_san  = '0;
      stepped   = '0;
      carry     = 1'b1;
      hi_nz     = 1'b0;
      nib       = '0;
      cur_dig   = '0;

      tick_c = ena && (presc_q == PW'(TICK_DIV - 1));
      step_c = tick_c && count_en && !load;

      for (int i = 0; i < int'(DIGITS); i++) begin
         nib = load_val[4*i +: 4];
         load_san[4*i +: 4] = (nib > 4'd9) ? 4'd0 : nib;
      end

      // Ripple carry/borrow through the BCD digits; carry out marks a wrap.
      for (int i = 0; i < int'(DIGITS); i++) begin
         nib = count_q[4*i +: 4];
         if (!carry) begin
            stepped[4*i +: 4] = nib;
         end else if (up_dn) begin
            if (nib == 4'd9) begin
               stepped[4*i +: 4] = 4'd0;
            end else begin
               stepped[4*i +: 4] = nib + 4'd1;
               carry = 1'b0;
            end
         end else begin
            if (nib == 4'd0) begin
               stepped[4*i +: 4] = 4'd9;
            end else begin
               stepped[4*i +: 4] = nib - 4'd1;
               carry = 1'b0;
            end
         end
      end

      if (ena) begin
         if (load || tick_c) begin
            presc_d = '0;
         end else begin
            presc_d = presc_q + PW'(1);
         end

         if (load) begin
            count_d = load_san;
         end else if (step_c) begin
            count_d = stepped;
            wrap_d  = carry;
         end

         if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
         end else begin
            scan_d = scan_q + SW'(1);
         end
      end

      // Blank a digit when it and every more significant digit are zero.
      for (int i = 0; i < int'(DIGITS); i++) begin
         if ((IW'(i) >= idx_q) && (count_q[4*i +: 4] != 4'd0)) begin
            hi_nz = 1'b1;
         end
      end
      blank   = (idx_q != '0) && !hi_nz;
      cur_dig = count_q[4*idx_q +: 4];

      if (ena) begin
         seg_d     = (blank ? 7'b0000000 : dec7(cur_dig)) ^ POL7;
         dig_sel_d = (DIGITS'(1) << idx_q) ^ POLD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q   <= '0;
         scan_q    <= '0;
         idx_q     <= '0;
         count_q   <= '0;
         wrap_q    <= 1'b0;
         seg_q     <= SEG_RST;
         dig_sel_q <= DIG_RST;
      end else begin
         presc_q   <= presc_d;
         scan_q    <= scan_d;
         idx_q     <= idx_d;
         count_q   <= count_d;
         wrap_q    <= wrap_d;
         seg_q     <= seg_d;
         dig_sel_q <= dig_sel_d;
      end
   end

   assign seg     = seg_q;
   assign dig_sel = dig_sel_q;
   assign count   = count_q;
   assign wrap    = wrap_q;

endmodule
